mac_dbl_accumulator: RTL and testbench

- Multiply-accumulate stage of the matrix-vector datapath.
- Consumes one row's element pairs (matrix coefficient, vector element), each DW bits wide, and forms their dot product at DW_DBL width.
- Presents the result with a valid/ack handshake. It sits directly upstream of the DW_DBL-wide result register, which captures acc_out when acc_valid is high.

---
 rtl/mac_dbl_accumulator.sv | 127 ++++++++++++
 tb/tb_mac_dbl_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dbl_accumulator.sv
// Multiply-accumulate stage: dot product of one row's element pairs,
// presented on a valid/ack handshake at double operand width.
module mac_dbl_accumulator #(
  parameter int DW     = 8,
  parameter int DW_DBL = 2 * DW,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  row_len,
  input  logic [DW-1:0]     a_in,
  input  logic [DW-1:0]     b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW_DBL-1:0] acc_out,
  output logic              acc_valid,
  input  logic              acc_ack,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW_DBL-1:0] r_acc;
  logic              r_ovf;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;

  logic              w_take_start;
  logic              w_beat;
  logic              w_last;
  logic [DW_DBL-1:0] w_prod;
  logic [DW_DBL:0]   w_sum;

  assign w_take_start = (r_state == S_IDLE) && start;
  assign w_beat       = (r_state == S_ACCUM) && in_valid;
  assign w_last       = (r_cnt == (r_len - LEN_W'(1)));
  assign w_prod       = DW_DBL'(a_in) * DW_DBL'(b_in);
  // Extra top bit captures the carry out of the accumulator.
  assign w_sum        = {1'b0, r_acc} + {1'b0, w_prod};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (row_len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_beat && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (acc_ack) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    acc_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        acc_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (w_take_start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
      if (row_len != '0) begin
        r_len <= row_len;
      end
    end else if (w_beat) begin
      r_acc <= w_sum[DW_DBL-1:0];
      r_cnt <= r_cnt + LEN_W'(1);
      if (w_sum[DW_DBL]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign acc_out = r_acc;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_mac_dbl_accumulator.sv
// Directed bench for mac_dbl_accumulator: arithmetic reference model
// compared every cycle, plus literal checks of the test-plan results.
module tb_mac_dbl_accumulator;

  localparam int DW     = 8;
  localparam int DW_DBL = 16;
  localparam int LEN_W  = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  row_len;
  logic [DW-1:0]     a_in;
  logic [DW-1:0]     b_in;
  logic              in_valid;
  logic              in_ready;
  logic [DW_DBL-1:0] acc_out;
  logic              acc_valid;
  logic              acc_ack;
  logic              ovf;
  logic              busy;

  int total_n = 0;
  int bad_n   = 0;

  mac_dbl_accumulator #(
    .DW(DW), .DW_DBL(DW_DBL), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(in_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ack(acc_ack),
    .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference: the row's unbounded running total; the outputs are
  // its low bits and whether it ever passed 2^DW_DBL.
  bit     m_init = 0;
  bit     m_accum = 0;
  bit     m_done = 0;
  longint m_total = 0;
  int     m_need = 0;
  int     m_got = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_init = 1;
      m_accum = 0;
      m_done = 0;
      m_total = 0;
    end else if (m_init) begin
      if (m_done) begin
        if (acc_ack) m_done = 0;
      end else if (m_accum) begin
        if (in_valid) begin
          m_total += longint'(a_in) * longint'(b_in);
          m_got++;
          if (m_got == m_need) begin
            m_accum = 0;
            m_done = 1;
          end
        end
      end else if (start) begin
        m_total = 0;
        m_got = 0;
        m_need = int'(row_len);
        if (row_len == 0) m_done = 1;
        else m_accum = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_acc_out", longint'(acc_out), m_total % 65536);
      chk("m_ovf", longint'(ovf), longint'(m_total >= 65536));
      chk("m_in_ready", longint'(in_ready), longint'(m_accum));
      chk("m_acc_valid", longint'(acc_valid), longint'(m_done));
      chk("m_busy", longint'(busy), longint'(m_accum | m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_row(input int len);
    start = 1'b1;
    row_len = LEN_W'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int b);
    in_valid = 1'b1;
    a_in = DW'(a);
    b_in = DW'(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
  endtask

  int vpat[7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    rst = 1'b0;
    start = 1'b0;
    row_len = '0;
    a_in = '0;
    b_in = '0;
    in_valid = 1'b0;
    acc_ack = 1'b0;
    tick();
    tick();
    chk("rst_acc", longint'(acc_out), 0);
    chk("rst_valid", longint'(acc_valid), 0);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    rst = 1'b1;
    tick();

    // basic row
    begin_row(3);
    beat(2, 3);
    beat(4, 5);
    beat(6, 7);
    chk("basic_acc", longint'(acc_out), 68);
    chk("basic_valid", longint'(acc_valid), 1);
    chk("basic_ovf", longint'(ovf), 0);
    ack();
    chk("basic_ack", longint'(acc_valid), 0);
    tick();

    // wrap and overflow, held under no ack
    begin_row(2);
    beat(255, 255);
    beat(255, 255);
    repeat (5) tick();
    chk("wrap_acc", longint'(acc_out), 'hFC02);
    chk("wrap_ovf", longint'(ovf), 1);
    chk("wrap_valid", longint'(acc_valid), 1);
    ack();
    begin_row(1);
    chk("wrap_ovf_clr", longint'(ovf), 0);
    beat(10, 10);
    chk("after_wrap", longint'(acc_out), 100);
    ack();

    // zero-length row
    begin_row(0);
    chk("zero_valid", longint'(acc_valid), 1);
    chk("zero_acc", longint'(acc_out), 0);
    chk("zero_ready", longint'(in_ready), 0);
    ack();

    // stalls, then in_valid pulses in DONE
    begin_row(4);
    a_in = 8'd1;
    b_in = 8'd1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i][0];
      tick();
    end
    in_valid = 1'b0;
    chk("stall_valid", longint'(acc_valid), 1);
    chk("stall_acc", longint'(acc_out), 4);
    beat(5, 5);
    beat(5, 5);
    chk("done_hold", longint'(acc_out), 4);
    ack();

    // reset mid-row
    begin_row(5);
    beat(2, 2);
    beat(2, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_acc", longint'(acc_out), 0);
    chk("mid_rst_valid", longint'(acc_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    begin_row(1);
    beat(3, 3);
    chk("post_rst_acc", longint'(acc_out), 9);
    ack();

    // ignored start in ACCUM and start+ack in DONE
    begin_row(3);
    start = 1'b1;
    row_len = 4'd1;
    beat(1, 2);
    chk("ign_no_done", longint'(acc_valid), 0);
    beat(1, 2);
    beat(1, 2);
    chk("ign_valid", longint'(acc_valid), 1);
    chk("ign_acc", longint'(acc_out), 6);
    row_len = 4'd2;
    ack();
    start = 1'b0;
    chk("ign_busy", longint'(busy), 0);
    chk("ign_ready", longint'(in_ready), 0);
    tick();
    chk("ign_idle", longint'(busy), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
